// File: rtl/avalon_nibble_mult_sequencer_pkg.sv
// avalon_nibble_mult_sequencer_pkg
//   Shared definitions for the nibble-serial multiply sequencer:
//   Avalon register addresses, CSR bit positions and the FSM state encoding.
package avalon_nibble_mult_sequencer_pkg;

  // Register map
  localparam logic [1:0] ADDR_A      = 2'd0;
  localparam logic [1:0] ADDR_B      = 2'd1;
  localparam logic [1:0] ADDR_CSR    = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  // CSR bit positions (START on write, BUSY/DONE on read)
  localparam int CSR_START = 0;
  localparam int CSR_BUSY  = 0;
  localparam int CSR_DONE  = 1;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/avalon_nibble_mult_sequencer.sv
// avalon_nibble_mult_sequencer
//   Avalon-MM slave computing a WIDTH x WIDTH unsigned product by feeding one
//   nibble pair per cycle to an external combinational 4x4 multiplier and
//   accumulating the shifted partial products (N*N cycles, N = WIDTH/4).
//
// Ports:
//   iClk, iReset_n          clock, asynchronous active-low reset
//   iChipSelect_n, iWrite_n, iRead_n, iAddress, iData
//                           Avalon-MM slave request (strobes active low)
//   oData                   registered read data (1-cycle latency)
//   oMulA, oMulB            nibble operands to the external 4x4 multiplier
//   iMulZ                   8-bit product back from the multiplier (same cycle)
//   oDone                   level copy of the status done bit
module avalon_nibble_mult_sequencer
  import avalon_nibble_mult_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iChipSelect_n,
  input  logic        iWrite_n,
  input  logic        iRead_n,
  input  logic [1:0]  iAddress,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic [3:0]  oMulA,
  output logic [3:0]  oMulB,
  input  logic [7:0]  iMulZ,
  output logic        oDone
);

  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t          state;
  state_t          stateNext;
  logic [WIDTH-1:0] regA;
  logic [WIDTH-1:0] regB;
  logic [RW-1:0]   acc;
  logic [IW-1:0]   idxI;
  logic [IW-1:0]   idxJ;

  logic            wrEn;
  logic            rdEn;
  logic            startReq;
  logic            busy;
  logic            done;
  logic            lastPair;
  logic [IW:0]     nibSum;
  logic [IW+2:0]   shiftAmt;
  logic [RW-1:0]   partial;
  logic [31:0]     readMux;

  // A write wins over a simultaneous read; the read is then dropped.
  assign wrEn     = ~iChipSelect_n & ~iWrite_n;
  assign rdEn     = ~iChipSelect_n & ~iRead_n & ~wrEn;
  assign startReq = wrEn && (iAddress == ADDR_CSR) && iData[CSR_START];
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign oDone    = done;
  assign lastPair = (idxI == LAST) && (idxJ == LAST);

  // Partial product weight is 16^(i+j), i.e. a shift of 4*(i+j) bits.
  assign nibSum   = {1'b0, idxI} + {1'b0, idxJ};
  assign shiftAmt = {nibSum, 2'b00};
  assign partial  = RW'(iMulZ) << shiftAmt;

  // Next-state logic: start is only honoured from IDLE or DONE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE, DONE: begin
        if (startReq) stateNext = RUN;
        else          stateNext = state;
      end
      RUN: begin
        if (lastPair) stateNext = DONE;
        else          stateNext = RUN;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Nibble operand selection; multiplier inputs are parked at zero outside RUN.
  always_comb begin
    oMulA = 4'd0;
    oMulB = 4'd0;
    if (busy) begin
      oMulA = regA[{idxI, 2'b00} +: 4];
      oMulB = regB[{idxJ, 2'b00} +: 4];
    end else begin
      oMulA = 4'd0;
      oMulB = 4'd0;
    end
  end

  // Read data selection, operands and result zero-extended to 32 bits.
  always_comb begin
    readMux = 32'd0;
    case (iAddress)
      ADDR_A:      readMux = 32'(regA);
      ADDR_B:      readMux = 32'(regB);
      ADDR_CSR:    readMux = {30'd0, done, busy};
      ADDR_RESULT: readMux = 32'(acc);
      default:     readMux = 32'd0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) state <= IDLE;
    else           state <= stateNext;
  end

  // Operand registers; frozen while a multiplication is running.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      regA <= '0;
      regB <= '0;
    end else if (wrEn && !busy) begin
      case (iAddress)
        ADDR_A:  regA <= iData[WIDTH-1:0];
        ADDR_B:  regB <= iData[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Accumulator and nibble indices: j is the inner loop, i the outer one.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      acc  <= '0;
      idxI <= '0;
      idxJ <= '0;
    end else if (startReq && !busy) begin
      acc  <= '0;
      idxI <= '0;
      idxJ <= '0;
    end else if (busy) begin
      acc <= acc + partial;
      if (idxJ == LAST) begin
        idxJ <= '0;
        idxI <= idxI + 1'b1;
      end else begin
        idxJ <= idxJ + 1'b1;
      end
    end
  end

  // Registered read data; holds when no read is accepted.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n)  oData <= 32'd0;
    else if (rdEn)  oData <= readMux;
  end

endmodule
